fetch: RTL and testbench
========================

# fetch

Instruction fetch stage: owns the PC, issues single-outstanding requests to instruction memory, and buffers returned instructions in a small FIFO. It presents them to the decode stage, one per cycle under decode's stall control. It is the producer of the `instr` stream decode consumes. It honours PC redirects from later stages and stops permanently on decode's `halt`.

## Interface
- `RESET_PC`, 16'h0000, PC fetched first after reset
- `DEPTH`, 2, instruction buffer entries (≥2, power of 2)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `imem_req`  out  1  fetch request, held until acked
- `imem_addr`  out  16  fetch address, stable while `imem_req`
- `imem_ack`  in  1  one-cycle response strobe; `imem_rdata` valid with it
- `imem_rdata`  in  16  returned instruction
- `instr`  out  16  head instruction to decode; 16'h0800 (NOP) when invalid
- `pc_plus2`  out  16  head instruction's address + 2; 0 when invalid
- `instr_valid`  out  1  head entry present
- `stall`  in  1  decode not accepting this cycle
- `redirect`  in  1  flush and restart at `redirect_pc`
- `redirect_pc`  in  16  new fetch address (bit 0 ignored, forced 0)
- `halt`  in  1  decode decoded HALT from current head
- `err`  out  1  sticky protocol error

## Operation
- States: RUN (normal issue), DROP (outstanding request is stale; discard its ack), HALTED.
- Reset (`rst`=0): state RUN, fetch PC = RESET_PC, FIFO empty, no request outstanding, all outputs 0 except `instr`=16'h0800.
- Issue rule, RUN only: `imem_req`=1 when (count + outstanding) < DEPTH. `imem_addr` = fetch PC. On `imem_ack`: push {rdata, PC+2} into FIFO, fetch PC += 2 (16-bit wrap, 16'hFFFE→16'h0000), outstanding cleared.
- Only one request outstanding. `imem_req` never drops before its ack except on redirect/halt.
- Consume: head popped when `instr_valid` && !`stall`. Push and pop in the same cycle when full are legal; count unchanged.
- Redirect: FIFO flushed, fetch PC = {redirect_pc[15:1],0}. If a request is outstanding and not acked this cycle, go DROP. In DROP `imem_req`=0; the next `imem_ack` is discarded, then return to RUN. An ack arriving in the redirect cycle is discarded; state stays RUN.
- Halt (sampled when `instr_valid`): FIFO flushed, go HALTED (via DROP-equivalent discard if outstanding). In HALTED `imem_req`=0, `instr_valid`=0 until reset. `redirect` with `halt` in the same cycle: redirect wins, halt ignored.
- `err` set, and held until reset, when `imem_ack` arrives with no request outstanding (not counting DROP's expected ack).

## Timing
- Ack at edge N → `instr_valid`=1 with that instruction from N+1.
- Zero-wait memory (ack in the request's first cycle): `imem_req` stays high and the address advances every cycle. Sustained 1 instr/cycle with no stall.
- Stall: FIFO fills to DEPTH, then `imem_req` deasserts the cycle after count+outstanding reaches DEPTH. It reasserts the cycle after a pop.
- Redirect at edge N: `instr_valid`=0 from N+1. `imem_req` with `imem_addr`=redirect_pc from N+1 (RUN) or after the stale ack (DROP).
- First request after reset release: cycle after `rst` rises, addr RESET_PC.
- Outputs are registered or decoded from registered state. No combinational path from `imem_ack` to `instr`/`instr_valid`. `imem_req` may depend combinationally only on state/count.

## Test plan
- Reset, zero-wait memory returning addr-as-data, `stall`=0 → `imem_addr` 0,2,4,6 on consecutive cycles; `instr` 0,2,4 one cycle later; `pc_plus2` 2,4,6.
- Memory with 3-cycle ack latency, `stall`=1 for 10 cycles → exactly DEPTH(2) acks accepted, `imem_req` low afterwards. Release stall → instructions from addr 0 and 2 are delivered in order, then addr 4 is requested.
- Request to addr 8 outstanding, `redirect`=1, `redirect_pc`=16'h0041 → DROP. Ack for 8 is discarded and never appears on `instr`. The next request is to 16'h0040.
- Redirect in the same cycle as ack of addr 6 → that data is discarded, FIFO is empty, and the next request is to `redirect_pc`.
- Head HALT with `halt`=1 → `instr_valid`=0 and `imem_req`=0 forever. `halt`+`redirect` to 16'h0100 together → fetch resumes at 16'h0100.
- Spurious `imem_ack` with nothing outstanding → `err`=1, held; assert `rst`=0 mid-fetch → all outputs to reset values immediately, `err`=0.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch: owns the PC, keeps one imem request in flight and queues returned words for decode.
// Ack at edge N is visible to decode from N+1. Requests stop once queue plus in-flight slots are full.

module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_dat,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head_dat,
    output logic [$clog2(DEPTH):0]   o_count
);
    // Flop-based FIFO with flush. Head readout is registered state only.
    // A push into a full FIFO is accepted when a pop happens in the same cycle.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign w_do_pop   = i_pop && (r_count != '0);
    assign w_do_push  = i_push && ((r_count != FULL) || w_do_pop);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

module fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        err
);
    // Fetch stage: one request in flight, DEPTH-entry buffer toward decode.
    // Ack-to-decode latency 1 cycle; requests pause while buffer + in-flight reach DEPTH.
    localparam int          CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [15:0] ins;
        logic [15:0] pc2;
    } entry_t;

    typedef enum logic [1:0] {RUN, DROP, HALTED} state_t;

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_pc, w_pc_nxt;
    logic          r_out, w_out_nxt;
    logic          r_err, w_err_nxt;
    logic          r_live;
    logic          w_req;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    entry_t        w_push_dat;
    entry_t        w_head;
    logic [CW-1:0] w_count;

    fetch_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (w_flush),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    // r_live holds requests off for the first cycle out of reset.
    assign w_req       = r_live && (r_state == RUN) && (r_out || (w_count < FULL));
    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == RUN) && (w_count != '0);
    assign instr       = instr_valid ? w_head.ins : 16'h0800;
    assign pc_plus2    = instr_valid ? w_head.pc2 : 16'h0000;
    assign err         = r_err;
    assign w_pop       = instr_valid && !stall;
    assign w_push_dat  = '{ins: imem_rdata, pc2: r_pc + 16'd2};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_out_nxt   = r_out;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        // An ack is expected only while requesting or while a stale one is owed.
        w_err_nxt   = r_err | (imem_ack && !w_req && !r_out);
        case (r_state)
            RUN: begin
                if (redirect) begin
                    w_flush   = 1'b1;
                    w_pc_nxt  = {redirect_pc[15:1], 1'b0};
                    w_out_nxt = w_req && !imem_ack;
                    if (w_req && !imem_ack) w_state_nxt = DROP;
                end else if (instr_valid && halt) begin
                    w_flush     = 1'b1;
                    w_out_nxt   = w_req && !imem_ack;
                    w_state_nxt = HALTED;
                end else if (w_req && imem_ack) begin
                    w_push    = 1'b1;
                    w_pc_nxt  = r_pc + 16'd2;
                    w_out_nxt = 1'b0;
                end else begin
                    w_out_nxt = w_req;
                end
            end
            DROP: begin
                if (redirect) w_pc_nxt = {redirect_pc[15:1], 1'b0};
                if (imem_ack) begin
                    w_out_nxt   = 1'b0;
                    w_state_nxt = RUN;
                end
            end
            HALTED: begin
                if (imem_ack) w_out_nxt = 1'b0;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_out   <= 1'b0;
            r_err   <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_out   <= w_out_nxt;
            r_err   <= w_err_nxt;
            r_live  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: zero-wait streaming, stalled slow memory, redirects, halt and error/reset.
module tb_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        err;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pc_plus2    (pc_plus2),
        .instr_valid (instr_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle after reset release, where the first request is visible.
    task automatic do_reset();
        rst = 1'b0; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        redirect_pc = 16'h0000; imem_rdata = 16'h0000;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("rst_req",   {15'd0, imem_req},    16'h0000);
        chk("rst_addr",  imem_addr,            16'h0000);
        chk("rst_instr", instr,                16'h0800);
        chk("rst_pc2",   pc_plus2,             16'h0000);
        chk("rst_vld",   {15'd0, instr_valid}, 16'h0000);
        chk("rst_err",   {15'd0, err},         16'h0000);
        tick();
        rst = 1'b1;
        tick();

        // Zero-wait memory, data = address, no stall.
        for (int k = 0; k < 4; k++) begin
            chk("s1_req",  {15'd0, imem_req}, 16'h0001);
            chk("s1_addr", imem_addr, 16'(2 * k));
            if (k > 0) begin
                chk("s1_instr", instr,    16'(2 * (k - 1)));
                chk("s1_pc2",   pc_plus2, 16'(2 * k));
            end
            imem_ack = 1'b1; imem_rdata = 16'(2 * k);
            tick();
        end
        imem_ack = 1'b0;
        chk("s1_instr3", instr,    16'h0006);
        chk("s1_pc2_3",  pc_plus2, 16'h0008);

        // Three-cycle memory with decode stalled.
        do_reset();
        stall = 1'b1;
        chk("s2_req0",  {15'd0, imem_req}, 16'h0001);
        chk("s2_addr0", imem_addr, 16'h0000);
        tick();
        tick();
        chk("s2_addr0b", imem_addr, 16'h0000);
        imem_ack = 1'b1; imem_rdata = 16'h1000;
        tick();
        imem_ack = 1'b0;
        chk("s2_vld",   {15'd0, instr_valid}, 16'h0001);
        chk("s2_instr", instr,     16'h1000);
        chk("s2_pc2",   pc_plus2,  16'h0002);
        chk("s2_addr2", imem_addr, 16'h0002);
        tick();
        tick();
        imem_ack = 1'b1; imem_rdata = 16'h1002;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("s2_full_req", {15'd0, imem_req}, 16'h0000);
            chk("s2_hold",     instr, 16'h1000);
            tick();
        end
        stall = 1'b0;
        chk("s2_rel_req",   {15'd0, imem_req}, 16'h0000);
        chk("s2_rel_instr", instr, 16'h1000);
        tick();
        chk("s2_instr2", instr,     16'h1002);
        chk("s2_pc2_2",  pc_plus2,  16'h0004);
        chk("s2_req4",   {15'd0, imem_req}, 16'h0001);
        chk("s2_addr4",  imem_addr, 16'h0004);
        tick();
        chk("s2_empty", instr, 16'h0800);
        chk("s2_pc2_0", pc_plus2, 16'h0000);

        // Redirect while the request for 8 is outstanding.
        imem_ack = 1'b1; imem_rdata = 16'h1004;
        tick();
        chk("s3_addr6", imem_addr, 16'h0006);
        imem_ack = 1'b1; imem_rdata = 16'h1006;
        tick();
        imem_ack = 1'b0;
        chk("s3_addr8", imem_addr, 16'h0008);
        chk("s3_instr", instr,     16'h1006);
        redirect = 1'b1; redirect_pc = 16'h0041;
        tick();
        redirect = 1'b0;
        chk("s3_drop_vld", {15'd0, instr_valid}, 16'h0000);
        chk("s3_drop_req", {15'd0, imem_req},    16'h0000);
        tick();
        imem_ack = 1'b1; imem_rdata = 16'h1008;
        tick();
        imem_ack = 1'b0;
        chk("s3_stale_vld", {15'd0, instr_valid}, 16'h0000);
        chk("s3_req40",  {15'd0, imem_req}, 16'h0001);
        chk("s3_addr40", imem_addr, 16'h0040);
        chk("s3_err",    {15'd0, err}, 16'h0000);
        imem_ack = 1'b1; imem_rdata = 16'h2040;
        tick();
        imem_ack = 1'b0;
        chk("s3_instr40", instr,     16'h2040);
        chk("s3_pc2_42",  pc_plus2,  16'h0042);
        chk("s3_addr42",  imem_addr, 16'h0042);

        // Redirect coinciding with the ack of address 6, then halt.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            imem_ack = 1'b1; imem_rdata = 16'(16'h3000 + 2 * k);
            tick();
        end
        chk("s4_addr6", imem_addr, 16'h0006);
        imem_ack = 1'b1; imem_rdata = 16'h3006; redirect = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        chk("s4_vld",   {15'd0, instr_valid}, 16'h0000);
        chk("s4_req",   {15'd0, imem_req},    16'h0001);
        chk("s4_addr",  imem_addr, 16'h0200);
        chk("s4_err",   {15'd0, err}, 16'h0000);
        imem_ack = 1'b1; imem_rdata = 16'hF000;
        tick();
        imem_ack = 1'b0;
        chk("s4_head", instr,     16'hF000);
        chk("s4_pc2",  pc_plus2,  16'h0202);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("s4_h_vld", {15'd0, instr_valid}, 16'h0000);
        chk("s4_h_req", {15'd0, imem_req},    16'h0000);
        chk("s4_h_ins", instr, 16'h0800);
        tick();
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        tick();
        imem_ack = 1'b0;
        chk("s4_h_err", {15'd0, err}, 16'h0000);
        repeat (3) tick();
        chk("s4_h_req_late", {15'd0, imem_req},    16'h0000);
        chk("s4_h_vld_late", {15'd0, instr_valid}, 16'h0000);

        // Halt together with redirect: redirect wins.
        do_reset();
        imem_ack = 1'b1; imem_rdata = 16'hF000;
        tick();
        imem_ack = 1'b0;
        chk("s5_head", instr, 16'hF000);
        halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100; stall = 1'b1;
        tick();
        halt = 1'b0; redirect = 1'b0;
        chk("s5_drop_req", {15'd0, imem_req}, 16'h0000);
        imem_ack = 1'b1; imem_rdata = 16'h5002;
        tick();
        imem_ack = 1'b0;
        chk("s5_req100",  {15'd0, imem_req}, 16'h0001);
        chk("s5_addr100", imem_addr, 16'h0100);
        chk("s5_err",     {15'd0, err}, 16'h0000);
        imem_ack = 1'b1; imem_rdata = 16'h4100;
        tick();
        chk("s5_instr",   instr,     16'h4100);
        chk("s5_addr102", imem_addr, 16'h0102);
        imem_rdata = 16'h4102;
        tick();
        imem_ack = 1'b0;
        chk("s5_full_req", {15'd0, imem_req}, 16'h0000);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("s6_err_set", {15'd0, err}, 16'h0001);
        chk("s6_instr",   instr, 16'h4100);
        tick();
        chk("s6_err_held", {15'd0, err}, 16'h0001);
        stall = 1'b0;
        tick();
        chk("s6_req",   {15'd0, imem_req}, 16'h0001);
        chk("s6_addr",  imem_addr, 16'h0104);
        chk("s6_instr2", instr, 16'h4102);
        rst = 1'b0;
        #1;
        chk("s6_rst_req",   {15'd0, imem_req},    16'h0000);
        chk("s6_rst_addr",  imem_addr,            16'h0000);
        chk("s6_rst_instr", instr,                16'h0800);
        chk("s6_rst_pc2",   pc_plus2,             16'h0000);
        chk("s6_rst_vld",   {15'd0, instr_valid}, 16'h0000);
        chk("s6_rst_err",   {15'd0, err},         16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
